multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have instruction, input, 32: instruction-register output; opcode = instruction[6:0]; valid from DECODE onward.
REQ-004 SHALL have memReady, input, 1: memory completes the current read/write in the cycle it is high.
REQ-005 SHALL have outputs pcWrite, pcWriteCond, irWrite, iOrD, memRead, memWrite, memtoReg, aluSrcA, regWrite, trap, each 1 bit.
REQ-006 SHALL have aluSrcB, output, 2: 00 = register, 01 = constant 4, 10 = immediate.
REQ-007 SHALL have aluOp, output, 2: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-008 SHALL have state, output, 3: current state encoding, for debug.
REQ-009 SHALL have retired, output, 32: count of completed instructions.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-011 FETCH SHALL drive memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00.
REQ-012 In FETCH, when memReady=1, SHALL pulse irWrite=1 and pcWrite=1 for that cycle and move to DECODE; otherwise SHALL hold FETCH with no strobes.
REQ-013 DECODE SHALL last exactly 1 cycle and drive aluSrcA=0, aluSrcB=10, aluOp=00 (branch target).
REQ-014 DECODE SHALL go to EXEC for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011, and to TRAP for any other opcode.
REQ-015 EXEC SHALL drive aluSrcA=1 for every class.
REQ-016 EXEC for R-type (0110011) SHALL drive aluSrcB=00, aluOp=10 and then go to WB.
REQ-017 EXEC for I-ALU (0010011) SHALL drive aluSrcB=10, aluOp=10 and then go to WB.
REQ-018 EXEC for load or store SHALL drive aluSrcB=10, aluOp=00 and then go to MEM.
REQ-019 EXEC for branch SHALL drive aluSrcB=00, aluOp=01, pcWriteCond=1 and then go to FETCH.
REQ-020 MEM SHALL drive iOrD=1, with memRead=1 for a load or memWrite=1 for a store, held until memReady=1.
REQ-021 On memReady=1 in MEM, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-022 WB SHALL drive regWrite=1 for exactly 1 cycle, with memtoReg=1 only for a load, and then go to FETCH.
REQ-023 retired SHALL increment by 1 on exit from WB, on store completion in MEM, and on branch exit from EXEC; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 TRAP SHALL be absorbing: trap=1, all strobes 0, left only via reset.
REQ-025 Every output not explicitly driven in a state SHALL be 0.
REQ-026 Outputs SHALL be combinational from state, opcode and memReady, with no added latency.
REQ-027 memReady SHALL be ignored in DECODE, EXEC, WB and TRAP.
REQ-028 Latency from FETCH entry to the next FETCH entry, with memReady constantly high, SHALL be 4 cycles for R/I, 5 for load, 4 for store and 3 for branch.

Reset
REQ-029 While rst_n=0, state SHALL be FETCH, retired SHALL be 0, trap SHALL be 0, and all strobes, including memRead, SHALL be 0.
REQ-030 Assertion of rst_n mid-operation SHALL abandon the instruction in flight immediately, with no regWrite or memWrite issued.
REQ-031 After rst_n deasserts, the first rising clk edge SHALL begin FETCH.

Structure
REQ-032 Opcode constants, the state enum, and the aluOp and aluSrcB encodings SHALL reside in the shared package control_pkg.
REQ-033 Opcode classification SHALL be one sub-module, instr_class_decode: instruction[6:0] in; isR, isI, isLoad, isStore, isBranch and isIllegal out.

Verification
REQ-034 Scenario: add (0x002081B3) with memReady=1 -> states 0,1,2,4,0; one regWrite cycle with memtoReg=0; retired=1.
REQ-035 Scenario: lw (0x0000A103) with FETCH memReady delayed 3 cycles and MEM memReady delayed 2 cycles -> memRead held 4 and 3 cycles respectively; WB has memtoReg=1; retired=1.
REQ-036 Scenario: sw (0x0020A023) -> memWrite=1 with iOrD=1 in MEM; regWrite never asserted; retired=1.
REQ-037 Scenario: beq (0x00208463) -> pcWriteCond=1 and aluOp=01 for exactly 1 cycle; back in FETCH 3 cycles after FETCH entry.
REQ-038 Scenario: opcode 0x7F -> TRAP and trap=1 held for 20 cycles, no strobes; rst_n pulse -> FETCH with retired=0.
REQ-039 Scenario: rst_n low during MEM of a store -> memWrite drops in the same cycle, retired unchanged at 0 and subsequently holds 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// ALU operation and ALU B-operand select codes.
package control_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrlStateT;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/instr_class_decode.sv
// Classifies a 7-bit opcode into the instruction classes the controller
// sequences; anything unrecognised is flagged illegal.
module instr_class_decode
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       isR,
    output logic       isI,
    output logic       isLoad,
    output logic       isStore,
    output logic       isBranch,
    output logic       isIllegal
);

    assign isR       = (opcode == OPC_RTYPE);
    assign isI       = (opcode == OPC_IALU);
    assign isLoad    = (opcode == OPC_LOAD);
    assign isStore   = (opcode == OPC_STORE);
    assign isBranch  = (opcode == OPC_BRANCH);
    assign isIllegal = ~(isR | isI | isLoad | isStore | isBranch);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing with an
// absorbing TRAP state and a retired-instruction counter.
module multicycle_control
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        irWrite,
    output logic        iOrD,
    output logic        memRead,
    output logic        memWrite,
    output logic        memtoReg,
    output logic        aluSrcA,
    output logic        regWrite,
    output logic        trap,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    // Memory handshake: memRead/memWrite are held as a request; the access
    // completes in the cycle memReady is high, which is also the cycle the FSM advances.

    ctrlStateT curState, nextState;
    logic      retireInc;
    logic      isR, isI, isLoad, isStore, isBranch, isIllegal;
    logic      unusedInstrBits;

    assign unusedInstrBits = ^instruction[31:7];

    instr_class_decode u_decode (
        .opcode    (instruction[6:0]),
        .isR       (isR),
        .isI       (isI),
        .isLoad    (isLoad),
        .isStore   (isStore),
        .isBranch  (isBranch),
        .isIllegal (isIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= FETCH;
            retired  <= 32'd0;
        end else begin
            curState <= nextState;
            if (retireInc)
                retired <= retired + 32'd1;
        end
    end

    assign state = curState;

    always_comb begin
        nextState   = curState;
        retireInc   = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        iOrD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memtoReg    = 1'b0;
        aluSrcA     = 1'b0;
        regWrite    = 1'b0;
        trap        = 1'b0;
        aluSrcB     = SRCB_REG;
        aluOp       = ALU_ADD;

        case (curState)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                if (memReady) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                aluSrcB   = SRCB_IMM;
                nextState = isIllegal ? TRAP : EXEC;
            end
            EXEC: begin
                aluSrcA = 1'b1;
                if (isR) begin
                    aluOp     = ALU_FUNCT;
                    nextState = WB;
                end else if (isI) begin
                    aluSrcB   = SRCB_IMM;
                    aluOp     = ALU_FUNCT;
                    nextState = WB;
                end else if (isLoad || isStore) begin
                    aluSrcB   = SRCB_IMM;
                    nextState = MEM;
                end else if (isBranch) begin
                    aluOp       = ALU_SUB;
                    pcWriteCond = 1'b1;
                    retireInc   = 1'b1;
                    nextState   = FETCH;
                end else begin
                    aluSrcA   = 1'b0;
                    nextState = TRAP;
                end
            end
            MEM: begin
                iOrD     = 1'b1;
                memRead  = isLoad;
                memWrite = isStore;
                if (!(isLoad || isStore)) begin
                    iOrD      = 1'b0;
                    nextState = TRAP;
                end else if (memReady) begin
                    nextState = isLoad ? WB : FETCH;
                    retireInc = isStore;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                memtoReg  = isLoad;
                retireInc = 1'b1;
                nextState = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                nextState = TRAP;
            end
        endcase

        // Reset is asynchronous, so strobes must be silenced combinationally too.
        if (!rst_n) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            irWrite     = 1'b0;
            iOrD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            memtoReg    = 1'b0;
            aluSrcA     = 1'b0;
            regWrite    = 1'b0;
            trap        = 1'b0;
            aluSrcB     = SRCB_REG;
            aluOp       = ALU_ADD;
            retireInc   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/output
// vectors are queued by hand and compared against the DUT each cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        memReady = 1'b0;
    logic        pcWrite, pcWriteCond, irWrite, iOrD, memRead, memWrite;
    logic        memtoReg, aluSrcA, regWrite, trap;
    logic [1:0]  aluSrcB, aluOp;
    logic [2:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    // Strobe order: pcWrite pcWriteCond irWrite iOrD memRead memWrite memtoReg aluSrcA regWrite trap
    localparam logic [9:0] PCW  = 10'b1000000000;
    localparam logic [9:0] PCWC = 10'b0100000000;
    localparam logic [9:0] IRW  = 10'b0010000000;
    localparam logic [9:0] IORD = 10'b0001000000;
    localparam logic [9:0] MRD  = 10'b0000100000;
    localparam logic [9:0] MWR  = 10'b0000010000;
    localparam logic [9:0] M2R  = 10'b0000001000;
    localparam logic [9:0] SRCA = 10'b0000000100;
    localparam logic [9:0] RW   = 10'b0000000010;
    localparam logic [9:0] TRP  = 10'b0000000001;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .irWrite     (irWrite),
        .iOrD        (iOrD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .memtoReg    (memtoReg),
        .aluSrcA     (aluSrcA),
        .regWrite    (regWrite),
        .trap        (trap),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .state       (state),
        .retired     (retired)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [31:0] obs;
    assign obs = {15'd0, state, pcWrite, pcWriteCond, irWrite, iOrD, memRead, memWrite,
                  memtoReg, aluSrcA, regWrite, trap, aluSrcB, aluOp};

    function automatic logic [31:0] mk(input logic [2:0] st, input logic [9:0] strobes,
                                       input logic [1:0] srcB, input logic [1:0] op);
        return {15'd0, st, strobes, srcB, op};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: reset pulse with checks while rst_n is low; returns at posedge+1
    task automatic doReset();
        rst_n    = 1'b0;
        memReady = 1'b1;
        @(negedge clk);
        checkVal("reset outputs", obs, mk(3'd0, 10'd0, 2'b00, 2'b00));
        checkVal("reset retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Driver: applies memReady bit i in cycle i, compares each cycle against expQ
    task automatic runVec(input string name, input logic [31:0] instr, input int n,
                          input logic [63:0] rdy);
        logic [31:0] exp;
        instruction = instr;
        for (int i = 0; i < n; i++) begin
            memReady = rdy[i];
            @(negedge clk);
            exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
            checkVal($sformatf("%s c%0d", name, i), obs, exp);
            @(posedge clk);
            #1;
        end
        checkVal({name, " leftover"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        doReset();

        // add x3,x1,x2
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA, 2'b00, 2'b10));
        expQ.push_back(mk(3'd4, RW, 2'b00, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("add", 32'h002081B3, 5, 64'b01111);
        checkVal("add retired", retired, 32'd1);

        // addi x1,x0,1
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA, 2'b10, 2'b10));
        expQ.push_back(mk(3'd4, RW, 2'b00, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("addi", 32'h00100093, 5, 64'b01111);
        checkVal("addi retired", retired, 32'd2);

        // lw with fetch ready after 3 waits and mem ready after 2 waits
        doReset();
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA, 2'b10, 2'b00));
        expQ.push_back(mk(3'd3, IORD | MRD, 2'b00, 2'b00));
        expQ.push_back(mk(3'd3, IORD | MRD, 2'b00, 2'b00));
        expQ.push_back(mk(3'd3, IORD | MRD, 2'b00, 2'b00));
        expQ.push_back(mk(3'd4, RW | M2R, 2'b00, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("lw", 32'h0000A103, 11, 64'b01100011000);
        checkVal("lw retired", retired, 32'd1);

        // sw
        doReset();
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA, 2'b10, 2'b00));
        expQ.push_back(mk(3'd3, IORD | MWR, 2'b00, 2'b00));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("sw", 32'h0020A023, 5, 64'b01101);
        checkVal("sw retired", retired, 32'd1);

        // beq: back in FETCH three cycles after FETCH entry
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA | PCWC, 2'b00, 2'b01));
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("beq", 32'h00208463, 4, 64'b0111);
        checkVal("beq retired", retired, 32'd2);

        // Illegal opcode: TRAP held for 20 cycles regardless of memReady
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        for (int i = 0; i < 20; i++)
            expQ.push_back(mk(3'd5, TRP, 2'b00, 2'b00));
        runVec("illegal", 32'h0000007F, 22, 64'h155555);
        checkVal("trap retired", retired, 32'd2);
        rst_n = 1'b0;
        #1;
        checkVal("trap rst outputs", obs, mk(3'd0, 10'd0, 2'b00, 2'b00));
        checkVal("trap rst retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("post trap", 32'h0000007F, 1, 64'b0);

        // Reset during MEM of a store abandons it
        doReset();
        expQ.push_back(mk(3'd0, PCW | IRW | MRD, 2'b01, 2'b00));
        expQ.push_back(mk(3'd1, 10'd0, 2'b10, 2'b00));
        expQ.push_back(mk(3'd2, SRCA, 2'b10, 2'b00));
        expQ.push_back(mk(3'd3, IORD | MWR, 2'b00, 2'b00));
        runVec("st abort", 32'h0020A023, 4, 64'b0111);
        memReady = 1'b0;
        #1;
        checkVal("st mem hold", obs, mk(3'd3, IORD | MWR, 2'b00, 2'b00));
        rst_n = 1'b0;
        #1;
        checkVal("st rst outputs", obs, mk(3'd0, 10'd0, 2'b00, 2'b00));
        checkVal("st rst retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            expQ.push_back(mk(3'd0, MRD, 2'b01, 2'b00));
        runVec("st after rst", 32'h0020A023, 3, 64'b000);
        checkVal("st after retired", retired, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
